// File: rtl/sat_round_cplx.sv
// rtl/sat_round_cplx.sv - two-stage shift/round/saturate stage for complex FFT samples
module sat_round_cplx #(
    parameter int IN_W    = 17,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_re,
    input  logic [IN_W-1:0]    in_im,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [1:0]         rnd_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_re,
    output logic [OUT_W-1:0]   out_im,
    output logic               out_sat,
    input  logic               clr_stats,
    output logic               sat_sticky,
    output logic [CNT_W-1:0]   sat_count
);

    localparam int MAX_SHIFT = IN_W - 1;
    localparam int TOP_W     = IN_W - OUT_W + 2;

    // Rounding modes as presented on rnd_mode.
    localparam logic [1:0] MODE_FLOOR = 2'd0;
    localparam logic [1:0] MODE_HALF_UP = 2'd1;
    localparam logic [1:0] MODE_CONVERGENT = 2'd2;

    logic               adv;
    logic [SHIFT_W-1:0] s_eff;
    logic [IN_W:0]      rnd_re;
    logic [IN_W:0]      rnd_im;
    logic [OUT_W:0]     sat_re;
    logic [OUT_W:0]     sat_im;

    logic               s1_valid;
    logic [IN_W:0]      s1_re;
    logic [IN_W:0]      s1_im;

    // Arithmetic right shift with optional rounding increment. The result is
    // one bit wider than the input so a round-up carry can never wrap.
    function automatic logic [IN_W:0] round_comp(
        input logic [IN_W-1:0]    x,
        input logic [SHIFT_W-1:0] s,
        input logic [1:0]         mode
    );
        logic signed [IN_W:0] xe;
        logic signed [IN_W:0] q;
        logic [IN_W-1:0]      bit_sel;
        logic                 r;
        logic                 t;
        logic                 inc;
        xe      = $signed({x[IN_W-1], x});
        q       = xe >>> s;
        bit_sel = '0;
        r       = 1'b0;
        t       = 1'b0;
        inc     = 1'b0;
        if (s != '0) begin
            // bit_sel marks the half-LSB position; everything below it is sticky.
            bit_sel = IN_W'(1) << (s - SHIFT_W'(1));
            r       = |(x & bit_sel);
            t       = |(x & (bit_sel - IN_W'(1)));
        end
        case (mode)
            MODE_HALF_UP:    inc = r;
            MODE_CONVERGENT: inc = r & (t | q[0]);
            default:         inc = 1'b0;
        endcase
        return q + (IN_W + 1)'(inc);
    endfunction

    // Clamp a rounded value into OUT_W bits; the MSB of the result is the
    // clamp flag. A value fits when all bits from the output sign bit upward
    // agree with the overall sign.
    function automatic logic [OUT_W:0] saturate(input logic [IN_W:0] q);
        logic fits;
        fits = (q[IN_W:OUT_W-1] == {TOP_W{q[IN_W]}});
        if (fits) begin
            return {1'b0, q[OUT_W-1:0]};
        end else if (q[IN_W]) begin
            return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    // Global pipeline advance: the whole pipe moves unless the output is stalled.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage-1 combinational path: clamp the shift, then round both components.
    always_comb begin
        s_eff  = shift;
        rnd_re = '0;
        rnd_im = '0;
        if (int'(shift) > MAX_SHIFT) begin
            s_eff = SHIFT_W'(MAX_SHIFT);
        end
        rnd_re = round_comp(in_re, s_eff, rnd_mode);
        rnd_im = round_comp(in_im, s_eff, rnd_mode);
    end

    // Stage-2 combinational path: saturate the registered rounded values.
    always_comb begin
        sat_re = saturate(s1_re);
        sat_im = saturate(s1_im);
    end

    // Stage-1 register: holds rounded samples and their valid bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_re    <= rnd_re;
            s1_im    <= rnd_im;
        end
    end

    // Stage-2 register: presents saturated samples, held stable while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            out_re    <= sat_re[OUT_W-1:0];
            out_im    <= sat_im[OUT_W-1:0];
            out_sat   <= sat_re[OUT_W] | sat_im[OUT_W];
        end
    end

    // Saturation statistics: counted once per transferred clamped sample,
    // clear takes priority, the counter holds at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_sticky <= 1'b0;
            sat_count  <= '0;
        end else if (clr_stats) begin
            sat_sticky <= 1'b0;
            sat_count  <= '0;
        end else if (out_valid && out_ready && out_sat) begin
            sat_sticky <= 1'b1;
            if (sat_count != {CNT_W{1'b1}}) begin
                sat_count <= sat_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sat_round_cplx.sv
// tb/tb_sat_round_cplx.sv - scoreboard bench for sat_round_cplx
module tb_sat_round_cplx;

    localparam int IN_W    = 17;
    localparam int OUT_W   = 16;
    localparam int SHIFT_W = 5;
    localparam int CNT_W   = 16;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_re;
    logic [IN_W-1:0]    in_im;
    logic [SHIFT_W-1:0] shift;
    logic [1:0]         rnd_mode;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_re;
    logic [OUT_W-1:0]   out_im;
    logic               out_sat;
    logic               clr_stats;
    logic               sat_sticky;
    logic [CNT_W-1:0]   sat_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*OUT_W:0] exp_q[$];

    logic             stall_prev = 1'b0;
    logic [2*OUT_W:0] held;

    sat_round_cplx #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .shift(shift), .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_sat(out_sat),
        .clr_stats(clr_stats), .sat_sticky(sat_sticky), .sat_count(sat_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: handshake rule, stall stability, and scoreboard pop on transfer.
    always @(negedge clock) begin
        check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", 64'({out_re, out_im, out_sat}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got re=0x%0h im=0x%0h, expected none",
                             out_re, out_im);
                end else begin
                    check("sample", 64'({out_re, out_im, out_sat}), 64'(exp_q.pop_front()));
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_re, out_im, out_sat};
        end
    end

    // Drive one sample; expected result is queued at the accepting edge.
    task automatic send(input logic [IN_W-1:0] re, input logic [IN_W-1:0] im,
                        input logic [SHIFT_W-1:0] sh, input logic [1:0] md,
                        input logic [OUT_W-1:0] e_re, input logic [OUT_W-1:0] e_im,
                        input logic e_sat);
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        shift    = sh;
        rnd_mode = md;
        for (int k = 0; k < 200 && !accepted; k++) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back({e_re, e_im, e_sat});
                accepted = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 200 cycles");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            @(posedge clock);
            #1;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        shift     = '0;
        rnd_mode  = '0;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_re", 64'(out_re), 64'd0);
        check("rst_out_im", 64'(out_im), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_sticky", 64'(sat_sticky), 64'd0);
        check("rst_count", 64'(sat_count), 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Passthrough with latency check: out_valid two edges after accept.
        in_valid = 1'b1; in_re = 17'h00123; in_im = 17'h1FF00; shift = 5'd0; rnd_mode = 2'd0;
        exp_q.push_back({16'h0123, 16'hFF00, 1'b0});
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("lat_1cyc", 64'(out_valid), 64'd0);
        @(posedge clock); #1;
        check("lat_2cyc", 64'(out_valid), 64'd1);
        drain();

        // Saturation at the 17->16 limit.
        send(17'h08000, 17'h00000, 5'd0, 2'd0, 16'h7FFF, 16'h0000, 1'b1);
        send(17'h17FFF, 17'h00000, 5'd0, 2'd0, 16'h8000, 16'h0000, 1'b1);
        drain();
        check("count_after_sat", 64'(sat_count), 64'd2);
        check("sticky_after_sat", 64'(sat_sticky), 64'd1);

        // Rounding vectors, shift 2.
        send(17'd6,      17'd7,      5'd2, 2'd0, 16'd1,      16'd1,      1'b0);
        send(17'd6,      17'd7,      5'd2, 2'd1, 16'd2,      16'd2,      1'b0);
        send(17'd6,      17'd7,      5'd2, 2'd2, 16'd2,      16'd2,      1'b0);
        send(17'd10,     17'h1FFF6,  5'd2, 2'd2, 16'd2,      16'hFFFE,   1'b0);
        send(17'h1FFFA,  17'd0,      5'd2, 2'd1, 16'hFFFF,   16'd0,      1'b0);
        send(17'h1FFFA,  17'd0,      5'd2, 2'd0, 16'hFFFE,   16'd0,      1'b0);
        send(17'd6,      17'd0,      5'd2, 2'd3, 16'd1,      16'd0,      1'b0);
        // Shift beyond IN_W-1 clamps to 16.
        send(17'h10000,  17'h0FFFF,  5'd31, 2'd1, 16'hFFFF,  16'd1,      1'b0);
        // Round-up carry into saturation.
        send(17'h0FFFF,  17'd0,      5'd1, 2'd1, 16'h7FFF,   16'd0,      1'b1);
        drain();
        check("count_after_carry", 64'(sat_count), 64'd3);

        // Backpressure: 8 samples with out_ready pattern 1,0,0,...
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(IN_W'(i * 3 + 1), IN_W'(-i), 5'd0, 2'd0,
                         OUT_W'(i * 3 + 1), OUT_W'(-i), 1'b0);
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = (c % 3 == 0);
                    @(posedge clock);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Clear coinciding with a saturated transfer.
        out_ready = 1'b0;
        send(17'h08000, 17'd0, 5'd0, 2'd0, 16'h7FFF, 16'd0, 1'b1);
        for (int k = 0; k < 20 && !out_valid; k++) begin
            @(posedge clock);
            #1;
        end
        check("stalled_valid", 64'(out_valid), 64'd1);
        @(posedge clock); #1;
        check("count_before_clr", 64'(sat_count), 64'd3);
        clr_stats = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        clr_stats = 1'b0;
        check("clr_count", 64'(sat_count), 64'd0);
        check("clr_sticky", 64'(sat_sticky), 64'd0);
        @(posedge clock); #1;
        check("clr_count_hold", 64'(sat_count), 64'd0);
        check("clr_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with two samples in flight.
        in_valid = 1'b1; in_re = 17'd5; in_im = 17'd9; shift = 5'd0; rnd_mode = 2'd0;
        @(posedge clock); #1;
        in_re = 17'd6;
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_flush_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            check("post_rst_idle", 64'(out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
